// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Bundle of the fetch port, the load/store port and the
//               single-port block-memory port of imem_port_arbiter.
//               Ports grouped here:
//                 if_req/if_addr           -> fetch request (in)
//                 if_gnt/if_rvalid/if_rdata <- fetch grant/response (out)
//                 dm_req/dm_we/dm_addr/dm_wdata -> data request (in)
//                 dm_gnt/dm_rvalid/dm_rdata  <- data grant/response (out)
//                 mem_wea/mem_addra/mem_dina -> memory inputs (out)
//                 mem_douta                  <- memory registered read data (in)
//               modport slave  : seen by the arbiter
//               modport master : seen by the requesters + memory
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   // load/store port
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   // memory port
   logic              mem_wea;
   logic [ADDR_W-1:0] mem_addra;
   logic [DATA_W-1:0] mem_dina;
   logic [DATA_W-1:0] mem_douta;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_wea, mem_addra, mem_dina,
      input  mem_douta
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_wea, mem_addra, mem_dina,
      output mem_douta
   );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one single-port 32-bit block memory between the
//               instruction-fetch stage and the load/store stage. At most one
//               access is issued per clock. The data port has fixed priority,
//               but after STARVE_MAX consecutive denied fetch cycles the fetch
//               port wins the next arbitration. The memory's registered douta
//               is steered back to whichever port issued the read one cycle
//               earlier.
// Ports       : clka       - clock, all state on rising edge
//               rsta_n     - asynchronous active-low reset
//               bus        - imem_port_arbiter_if.slave (fetch, data and
//                            memory ports; see the interface file)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  wire logic            clka,
   input  wire logic            rsta_n,
   imem_port_arbiter_if.slave   bus
);

   // Starvation counter needs to hold STARVE_MAX, and never narrower than 2 bits.
   localparam int CNT_RAW = $clog2(STARVE_MAX + 1);
   localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   // Owner of the memory read data that appears in the next cycle.
   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_IF   = 2'd1,
      RSP_DM   = 2'd2
   } rsp_t;

   rsp_t              rsp_state;
   logic [CNT_W-1:0]  starve_cnt;
   logic              if_rvalid_q;
   logic              dm_rvalid_q;
   logic [DATA_W-1:0] if_rdata_hold;
   logic [DATA_W-1:0] dm_rdata_hold;

   logic              starved;
   logic              if_gnt_c;
   logic              dm_gnt_c;
   logic              mem_wea_c;
   logic [ADDR_W-1:0] mem_addra_c;
   logic [DATA_W-1:0] mem_dina_c;

   assign starved = (starve_cnt == CNT_MAX);

   // ------------------------------------------------------------------------
   // Arbitration. Grants are combinational on the current requests. They are
   // also qualified by rsta_n so that nothing reaches the memory while reset
   // is asserted, even in the middle of a clock cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      if_gnt_c = 1'b0;
      dm_gnt_c = 1'b0;
      if (rsta_n) begin
         if (bus.if_req && (!bus.dm_req || starved)) begin
            if_gnt_c = 1'b1;
         end else if (bus.dm_req) begin
            dm_gnt_c = 1'b1;
         end
      end
   end

   // Memory-side mux: idle cycles drive all zeros onto the memory port.
   always_comb begin
      mem_wea_c   = 1'b0;
      mem_addra_c = '0;
      mem_dina_c  = '0;
      if (if_gnt_c) begin
         mem_addra_c = bus.if_addr;
      end else if (dm_gnt_c) begin
         mem_wea_c   = bus.dm_we;
         mem_addra_c = bus.dm_addr;
         mem_dina_c  = bus.dm_wdata;
      end
   end

   assign bus.if_gnt    = if_gnt_c;
   assign bus.dm_gnt    = dm_gnt_c;
   assign bus.mem_wea   = mem_wea_c;
   assign bus.mem_addra = mem_addra_c;
   assign bus.mem_dina  = mem_dina_c;

   // ------------------------------------------------------------------------
   // Response FSM, starvation counter and read-data holding registers.
   // The rvalid flags are registered copies of the state decode; the rdata
   // holding registers capture mem_douta in the owning cycle so that a port
   // not being served keeps showing its last returned word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         rsp_state     <= RSP_NONE;
         starve_cnt    <= '0;
         if_rvalid_q   <= 1'b0;
         dm_rvalid_q   <= 1'b0;
         if_rdata_hold <= '0;
         dm_rdata_hold <= '0;
      end else begin
         // next owner of mem_douta; stores produce no response
         if (if_gnt_c) begin
            rsp_state   <= RSP_IF;
            if_rvalid_q <= 1'b1;
            dm_rvalid_q <= 1'b0;
         end else if (dm_gnt_c && !bus.dm_we) begin
            rsp_state   <= RSP_DM;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b1;
         end else begin
            rsp_state   <= RSP_NONE;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
         end

         // count consecutive denied fetch cycles, saturating
         if (!bus.if_req || if_gnt_c) begin
            starve_cnt <= '0;
         end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         // latch the word delivered this cycle for the owning port
         case (rsp_state)
            RSP_IF:  if_rdata_hold <= bus.mem_douta;
            RSP_DM:  dm_rdata_hold <= bus.mem_douta;
            default: ;
         endcase
      end
   end

   // Read data is live from the memory in the response cycle, held otherwise.
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.if_rdata  = (rsp_state == RSP_IF) ? bus.mem_douta : if_rdata_hold;
   assign bus.dm_rdata  = (rsp_state == RSP_DM) ? bus.mem_douta : dm_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed self-checking bench for imem_port_arbiter with a
//               behavioural single-port block memory (registered douta).
//               Memory word i is preloaded with 32'hC0DE_0000 + i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 3;

   logic clka;
   logic rsta_n;

   int n_cmp;
   int n_err;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   imem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clka   (clka),
      .rsta_n (rsta_n),
      .bus    (bus.slave)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   // Block memory model: synchronous write, registered read.
   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC0DE_0000 + i;
      bus.mem_douta = '0;
   end

   always @(posedge clka) begin
      if (bus.mem_wea) mem[bus.mem_addra] <= bus.mem_dina;
      bus.mem_douta <= mem[bus.mem_addra];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rsta_n = 1'b1;
      idle();

      // ---------------- reset state (with a pending fetch) ----------------
      #1 rsta_n = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 5'd2;
      #1;
      chk("rst_if_gnt",    {31'd0, bus.if_gnt},    32'd0);
      chk("rst_dm_gnt",    {31'd0, bus.dm_gnt},    32'd0);
      chk("rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
      chk("rst_dm_rvalid", {31'd0, bus.dm_rvalid}, 32'd0);
      chk("rst_if_rdata",  bus.if_rdata,           32'd0);
      chk("rst_dm_rdata",  bus.dm_rdata,           32'd0);
      chk("rst_mem_wea",   {31'd0, bus.mem_wea},   32'd0);
      chk("rst_mem_addra", {27'd0, bus.mem_addra}, 32'd0);
      chk("rst_mem_dina",  bus.mem_dina,           32'd0);
      @(negedge clka);
      @(negedge clka);
      idle();
      rsta_n = 1'b1;

      // ---------------- fetch only: addresses 0,1,2 ----------------
      @(negedge clka);
      bus.if_req = 1'b1; bus.if_addr = 5'd0;
      #1;
      chk("f0_if_gnt",  {31'd0, bus.if_gnt},    32'd1);
      chk("f0_dm_gnt",  {31'd0, bus.dm_gnt},    32'd0);
      chk("f0_addra",   {27'd0, bus.mem_addra}, 32'd0);
      @(negedge clka);
      bus.if_addr = 5'd1;
      #1;
      chk("f1_if_gnt",  {31'd0, bus.if_gnt},    32'd1);
      chk("f1_addra",   {27'd0, bus.mem_addra}, 32'd1);
      chk("f1_rvalid",  {31'd0, bus.if_rvalid}, 32'd1);
      chk("f1_rdata",   bus.if_rdata,           32'hC0DE_0000);
      chk("f1_dm_rv",   {31'd0, bus.dm_rvalid}, 32'd0);
      @(negedge clka);
      bus.if_addr = 5'd2;
      #1;
      chk("f2_if_gnt",  {31'd0, bus.if_gnt},    32'd1);
      chk("f2_rvalid",  {31'd0, bus.if_rvalid}, 32'd1);
      chk("f2_rdata",   bus.if_rdata,           32'hC0DE_0001);
      @(negedge clka);
      idle();
      #1;
      chk("f3_if_gnt",  {31'd0, bus.if_gnt},    32'd0);
      chk("f3_wea",     {31'd0, bus.mem_wea},   32'd0);
      chk("f3_rvalid",  {31'd0, bus.if_rvalid}, 32'd1);
      chk("f3_rdata",   bus.if_rdata,           32'hC0DE_0002);
      @(negedge clka);
      #1;
      chk("f4_rvalid",  {31'd0, bus.if_rvalid}, 32'd0);
      chk("f4_hold",    bus.if_rdata,           32'hC0DE_0002);
      chk("f4_dm_rv",   {31'd0, bus.dm_rvalid}, 32'd0);

      // ---------------- store then load to address 4 ----------------
      @(negedge clka);
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 5'd4; bus.dm_wdata = 32'h0000_0018;
      #1;
      chk("st_dm_gnt",  {31'd0, bus.dm_gnt},    32'd1);
      chk("st_if_gnt",  {31'd0, bus.if_gnt},    32'd0);
      chk("st_wea",     {31'd0, bus.mem_wea},   32'd1);
      chk("st_addra",   {27'd0, bus.mem_addra}, 32'd4);
      chk("st_dina",    bus.mem_dina,           32'h0000_0018);
      @(negedge clka);
      bus.dm_we = 1'b0; bus.dm_wdata = '0;
      #1;
      chk("ld_dm_gnt",  {31'd0, bus.dm_gnt},    32'd1);
      chk("ld_wea",     {31'd0, bus.mem_wea},   32'd0);
      chk("ld_addra",   {27'd0, bus.mem_addra}, 32'd4);
      chk("st_no_rv",   {31'd0, bus.dm_rvalid}, 32'd0);
      @(negedge clka);
      idle();
      #1;
      chk("ld_rvalid",  {31'd0, bus.dm_rvalid}, 32'd1);
      chk("ld_rdata",   bus.dm_rdata,           32'h0000_0018);
      chk("ld_if_rv",   {31'd0, bus.if_rvalid}, 32'd0);
      chk("ld_if_hold", bus.if_rdata,           32'hC0DE_0002);

      // ---------------- contention: dm,dm,dm,if repeating ----------------
      @(negedge clka);
      bus.if_req = 1'b1; bus.if_addr = 5'd7;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 5'd9;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clka);
         #1;
         chk("ct_if_gnt", {31'd0, bus.if_gnt}, {31'd0, (k % 4) == 3});
         chk("ct_dm_gnt", {31'd0, bus.dm_gnt}, {31'd0, (k % 4) != 3});
         chk("ct_addra",  {27'd0, bus.mem_addra}, ((k % 4) == 3) ? 32'd7 : 32'd9);
         if (k == 0) begin
            chk("ct_if_rv0", {31'd0, bus.if_rvalid}, 32'd0);
            chk("ct_dm_rv0", {31'd0, bus.dm_rvalid}, 32'd0);
         end else begin
            chk("ct_if_rv", {31'd0, bus.if_rvalid}, {31'd0, ((k - 1) % 4) == 3});
            chk("ct_dm_rv", {31'd0, bus.dm_rvalid}, {31'd0, ((k - 1) % 4) != 3});
            if (((k - 1) % 4) == 3) chk("ct_if_rdata", bus.if_rdata, 32'hC0DE_0007);
            else                    chk("ct_dm_rdata", bus.dm_rdata, 32'hC0DE_0009);
         end
      end
      @(negedge clka);
      idle();
      #1;
      chk("ct_end_if_rv", {31'd0, bus.if_rvalid}, 32'd1);
      chk("ct_end_rdata", bus.if_rdata,           32'hC0DE_0007);
      @(negedge clka);

      // ---------------- simultaneous single-cycle requests ----------------
      @(negedge clka);
      bus.if_req = 1'b1; bus.if_addr = 5'd3;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 5'd5;
      #1;
      chk("sm_dm_gnt",  {31'd0, bus.dm_gnt},    32'd1);
      chk("sm_if_gnt",  {31'd0, bus.if_gnt},    32'd0);
      @(negedge clka);
      bus.dm_req = 1'b0; bus.dm_addr = '0;
      #1;
      chk("sm_if_gnt2", {31'd0, bus.if_gnt},    32'd1);
      chk("sm_addra2",  {27'd0, bus.mem_addra}, 32'd3);
      chk("sm_dm_rv",   {31'd0, bus.dm_rvalid}, 32'd1);
      chk("sm_dm_rd",   bus.dm_rdata,           32'hC0DE_0005);
      @(negedge clka);
      idle();
      #1;
      chk("sm_if_rv",   {31'd0, bus.if_rvalid}, 32'd1);
      chk("sm_if_rd",   bus.if_rdata,           32'hC0DE_0003);
      chk("sm_dm_rv2",  {31'd0, bus.dm_rvalid}, 32'd0);

      // ---------------- reset in the cycle a fetch is granted ----------------
      @(negedge clka);
      bus.if_req = 1'b1; bus.if_addr = 5'd6;
      #1;
      chk("rm_if_gnt",  {31'd0, bus.if_gnt},    32'd1);
      #1 rsta_n = 1'b0;
      #1;
      chk("rm_gnt_rst", {31'd0, bus.if_gnt},    32'd0);
      chk("rm_addra",   {27'd0, bus.mem_addra}, 32'd0);
      @(negedge clka);
      #1;
      chk("rm_if_rv",   {31'd0, bus.if_rvalid}, 32'd0);
      chk("rm_if_rd",   bus.if_rdata,           32'd0);
      chk("rm_dm_rd",   bus.dm_rdata,           32'd0);
      rsta_n = 1'b1;
      #1;
      chk("rm_post_gnt", {31'd0, bus.if_gnt},   32'd1);
      chk("rm_post_rv",  {31'd0, bus.if_rvalid}, 32'd0);
      @(negedge clka);
      idle();
      #1;
      chk("rm_post_rv2", {31'd0, bus.if_rvalid}, 32'd1);
      chk("rm_post_rd",  bus.if_rdata,           32'hC0DE_0006);

      @(negedge clka);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbiter and sequencer that shares the single-port 32-bit block instruction/data memory between the instruction-fetch stage and the load/store stage of the RISC core. It accepts at most one access per clock, drives the memory's `wea/addra/dina` inputs, and returns the memory's registered `douta` to whichever requester issued the read one cycle earlier. Data-port priority is fixed, with a starvation counter so that a stream of loads/stores cannot stall fetch indefinitely.

## Interface
- `ADDR_W`, 5: memory word-address width (32 words).
- `DATA_W`, 32: word width.
- `STARVE_MAX`, 3: consecutive denied fetch cycles after which fetch wins the next arbitration.

- `clka`  in  1  single clock; all state updates on its rising edge.
- `rsta_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  fetch read request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  combinational grant to fetch this cycle.
- `if_rvalid`  out  1  registered; `if_rdata` valid this cycle.
- `if_rdata`  out  DATA_W  fetch read data.
- `dm_req`  in  1  data request; held with `dm_we/dm_addr/dm_wdata` until `dm_gnt`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  data word address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_gnt`  out  1  combinational grant to data port this cycle.
- `dm_rvalid`  out  1  registered; `dm_rdata` valid this cycle (loads only).
- `dm_rdata`  out  DATA_W  load data.
- `mem_wea`  out  1  to memory `wea`.
- `mem_addra`  out  ADDR_W  to memory `addra`.
- `mem_dina`  out  DATA_W  to memory `dina`.
- `mem_douta`  in  DATA_W  from memory `douta` (registered in memory, one-cycle read latency).

## Operation
- Arbitration each cycle (combinational on current requests and state):
  - neither req: no grant; `mem_wea`=0, `mem_addra`=0, `mem_dina`=0.
  - only one req: that port granted.
  - both req: `dm` granted unless `starve_cnt == STARVE_MAX`, in which case `if` granted.
- Exactly one of `if_gnt`/`dm_gnt` high when any request is present; never both.
- Granted port's address (and for `dm`, `dm_we`/`dm_wdata`) drive the memory port; `mem_wea` = `dm_gnt & dm_we`.
- `starve_cnt` (2+ bits, saturating at STARVE_MAX): increments when `if_req & ~if_gnt`; clears when `if_gnt` or `~if_req`.
- Response FSM, states RSP_NONE, RSP_IF, RSP_DM (registered owner of next `mem_douta`):
  - next = RSP_IF on `if_gnt`; RSP_DM on `dm_gnt & ~dm_we`; else RSP_NONE (stores produce no response).
  - RSP_IF: `if_rvalid`=1, `if_rdata`=`mem_douta`; RSP_DM: `dm_rvalid`=1, `dm_rdata`=`mem_douta`.
  - rdata of a non-owning port holds its last returned value.
- Store followed by load to same address: load granted the next cycle returns the new data (memory write completes at the grant edge).
- Back-to-back grants sustained: one access per cycle, throughput 1.

## Timing
- Grant: same cycle as request (zero latency), combinational.
- Read latency: grant in cycle N -> rvalid and rdata in cycle N+1.
- Store completes at the rising edge ending the grant cycle; no rvalid.
- Reset (asynchronous assert, `rsta_n`=0): FSM -> RSP_NONE, `starve_cnt`=0, `if_rvalid`=`dm_rvalid`=0, `if_rdata`=`dm_rdata`=0; grants and memory-side outputs are 0 while in reset. A read granted in the cycle reset asserts produces no rvalid after release.
- Release of `rsta_n` is synchronous to `clka`; first grant possible in the first cycle after release.

## Test plan
- Fetch only: `if_req` with addresses 0,1,2 on consecutive cycles -> `if_gnt`=1 each cycle, `if_rvalid` N+1 with memory words 0,1,2; `dm_*` outputs idle.
- Store then load: `dm_we`=1 addr 4 data 0x0000_0018, next cycle load addr 4 -> `mem_wea`=1 for one cycle, `dm_rvalid` one cycle after load with 0x0000_0018, no rvalid for store.
- Contention: `if_req` and `dm_req` held high continuously, STARVE_MAX=3 -> grant pattern dm,dm,dm,if repeating; `starve_cnt` returns to 0 after each fetch grant.
- Simultaneous single-cycle requests: both asserted once with `starve_cnt`=0 -> `dm_gnt`=1, `if_gnt`=0; fetch held, granted following cycle; rvalids in cycles N+1 (dm) and N+2 (if).
- Reset mid-operation: assert `rsta_n`=0 in the cycle a fetch read is granted -> `if_rvalid` stays 0, all outputs 0, first post-release fetch returns correct data one cycle after grant.
